mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the pipelined MIPS core; sits directly downstream of the ALU.
//  Takes the ALU result plus the instruction context and performs lw/sw on a
//  word-addressed data RAM. The ALU result is already a word index (base + imm/4).
//  Emits the MEM/WB record and stalls upstream while a multi-cycle access is in flight.
// PARAMETERS
//  ADDR_W       8   data RAM word-index width; DEPTH = 2**ADDR_W words
//  MEM_LATENCY  2   extra wait cycles per lw/sw (0 = single-cycle access)
// PORTS
//  clk            in   1   core clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  ex_valid       in   1   EX record valid this cycle
//  ex_ready       out  1   stage can accept; transfer on ex_valid & ex_ready
//  ex_opcode      in   6   instruction opcode field
//  ex_result      in   32  ALU result (word index for lw/sw, data otherwise)
//  ex_store_data  in   32  rt value for sw
//  ex_dest        in   5   destination register number
//  ex_reg_write   in   1   instruction writes the register file
//  wb_valid       out  1   MEM/WB record valid (one-cycle pulse per instruction)
//  wb_data        out  32  load data (lw) or passed-through ALU result
//  wb_dest        out  5   destination register
//  wb_reg_write   out  1   write-enable toward WB; forced 0 for sw and on addr_err
//  wb_is_load     out  1   record came from lw
//  addr_err       out  1   pulse with wb_valid: lw/sw index had nonzero bits >= ADDR_W
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; wb_valid, wb_reg_write, wb_is_load and addr_err = 0;
//   wb_data = 0; wb_dest = 0; ex_ready = 1 one cycle after deassertion. RAM contents are not reset.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: ex_ready=1. On accept:
//    - non-memory opcode: register the record, wb_valid=1 next cycle, wb_data=ex_result (latency 1).
//      The state stays IDLE (back-to-back throughput 1/cycle).
//    - lw (6'b100011) / sw (6'b101011): latch opcode/index/store data/dest; go to WAIT.
//      If MEM_LATENCY==0, skip WAIT and go to DONE.
//   WAIT: ex_ready=0; counter runs 0..MEM_LATENCY-1; on the last count go to DONE.
//   DONE: ex_ready=0. The sw write commits at this edge (index = low ADDR_W bits).
//    lw reads the RAM combinationally. Outputs register on this edge: wb_valid=1,
//    wb_is_load=lw, wb_reg_write=lw & ex_reg_write & ~addr_err. The state goes to IDLE.
//   lw/sw latency from accept to wb_valid: MEM_LATENCY+2 cycles.
//  Width rules: index = ex_result[ADDR_W-1:0]. addr_err = |ex_result[31:ADDR_W] for lw/sw only.
//   On addr_err, a sw does not write and a lw returns wb_data=0.
//  Ordering: a sw commits before the next accept, so a lw to the same index issued
//   immediately after returns the new data (no bypass needed).
//  ex_valid=0 in IDLE: wb_valid=0 next cycle; the other wb_* outputs hold their last values.
//  Inputs are ignored while ex_ready=0. Upstream must hold its record stable until the transfer.
//  Reset during WAIT/DONE: the pending sw is dropped (RAM unchanged) and no wb_valid is produced.
//  Unknown opcodes are treated as non-memory pass-through.
// STRUCTURE
//  Shared package mips_pkg: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE opcode constants;
//   REG_W=5, DATA_W=32; mem_state_t enum {IDLE, WAIT, DONE}.
//  Sub-module data_ram (ADDR_W): synchronous write port (we, waddr, wdata), combinational read
//   port (raddr -> rdata). Instantiated once. The FSM, counter and MEM/WB registers live in mem_stage.
// TESTING
//  1. rst_n=0 mid-stream, then 1 -> all wb_* = 0, ex_ready=1, addr_err=0.
//  2. addu record: ex_result=32'h0000_1234, dest=5, reg_write=1 -> next cycle wb_valid=1,
//     wb_data=32'h1234, wb_dest=5, wb_is_load=0; 4 back-to-back records produce 4 consecutive wb_valid.
//  3. sw index 3, data 32'hDEAD_BEEF, then lw index 3, dest 8 (MEM_LATENCY=2) -> ex_ready low 3
//     cycles per op; lw wb_valid 4 cycles after accept; wb_data=32'hDEADBEEF, wb_reg_write=1.
//  4. lw with ex_result=32'h0000_0100 (ADDR_W=8) -> addr_err=1, wb_reg_write=0, wb_data=0;
//     sw at the same index -> RAM index 0 unchanged.
//  5. sw index 7 data 32'h1 accepted, rst_n pulsed low during WAIT -> no wb_valid;
//     a later lw index 7 returns the pre-sw value.
//  6. MEM_LATENCY=0 build: lw accepted -> wb_valid 2 cycles later; ex_ready low exactly 1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcode constants, datapath widths
// and the MEM-stage FSM state type.
package mips_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM for the MEM stage.
// Ports:
//   i_clk            write clock, rising edge
//   i_we             write enable
//   i_waddr/i_wdata  synchronous write port
//   i_raddr/o_rdata  combinational read port
// Contents are not reset.
module data_ram
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the pipelined MIPS core. Passes non-memory records through with
// one cycle of latency and performs lw/sw on the data RAM, stalling upstream
// for MEM_LATENCY wait cycles plus one commit cycle.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ex_*               EX record in; transfer on ex_valid & ex_ready
//   wb_*               MEM/WB record out; wb_valid pulses once per instruction
//   addr_err           pulses with wb_valid when a lw/sw index is out of range
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              ex_reg_write,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_reg_write,
  output logic              wb_is_load,
  output logic              addr_err
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  mem_state_t r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;

  // Latched memory request
  logic              r_is_lw;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_sdata;
  logic [REG_W-1:0]  r_dest;
  logic              r_reg_write;

  // MEM/WB record
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_W-1:0]  r_wb_dest;
  logic              r_wb_reg_write;
  logic              r_wb_is_load;
  logic              r_addr_err;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_err;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_rdata;

  assign ex_ready = (r_state == IDLE);
  assign w_accept = ex_valid & ex_ready;
  assign w_is_mem = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
  assign w_err    = |r_result[DATA_W-1:ADDR_W];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_ram_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem) begin
          w_state_d = (MEM_LATENCY == 0) ? DONE : WAIT;
          w_cnt_d   = '0;
        end
      end
      WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_d = DONE;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      DONE: begin
        // Store commits on the same edge that returns to IDLE, so a following
        // lw always sees it.
        w_ram_we  = ~r_is_lw & ~w_err;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_is_lw        <= 1'b0;
      r_result       <= '0;
      r_sdata        <= '0;
      r_dest         <= '0;
      r_reg_write    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_dest      <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_is_load   <= 1'b0;
      r_addr_err     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_wb_valid <= 1'b0;
      if (w_accept && w_is_mem) begin
        r_is_lw     <= (ex_opcode == OP_LW);
        r_result    <= ex_result;
        r_sdata     <= ex_store_data;
        r_dest      <= ex_dest;
        r_reg_write <= ex_reg_write;
      end
      if (w_accept && !w_is_mem) begin
        r_wb_valid     <= 1'b1;
        r_wb_data      <= ex_result;
        r_wb_dest      <= ex_dest;
        r_wb_reg_write <= ex_reg_write;
        r_wb_is_load   <= 1'b0;
        r_addr_err     <= 1'b0;
      end else if (r_state == DONE) begin
        r_wb_valid     <= 1'b1;
        // sw forwards its ALU result; an out-of-range lw returns zero
        r_wb_data      <= r_is_lw ? (w_err ? '0 : w_ram_rdata) : r_result;
        r_wb_dest      <= r_dest;
        r_wb_reg_write <= r_is_lw & r_reg_write & ~w_err;
        r_wb_is_load   <= r_is_lw;
        r_addr_err     <= w_err;
      end
    end
  end

  data_ram #(
    .ADDR_W(ADDR_W)
  ) u_data_ram (
    .i_clk  (clk),
    .i_we   (w_ram_we),
    .i_waddr(r_result[ADDR_W-1:0]),
    .i_wdata(r_sdata),
    .i_raddr(r_result[ADDR_W-1:0]),
    .o_rdata(w_ram_rdata)
  );

  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_dest      = r_wb_dest;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_is_load   = r_wb_is_load;
  assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Bench for mem_stage: instance 0 built with MEM_LATENCY=2, instance 1 with 0.
// A transaction-level model predicts every output each cycle; directed
// sequences add literal expectations.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid      [2];
  logic [5:0]  ex_opcode     [2];
  logic [31:0] ex_result     [2];
  logic [31:0] ex_store_data [2];
  logic [4:0]  ex_dest       [2];
  logic        ex_reg_write  [2];
  logic        ex_ready      [2];
  logic        wb_valid      [2];
  logic [31:0] wb_data       [2];
  logic [4:0]  wb_dest       [2];
  logic        wb_reg_write  [2];
  logic        wb_is_load    [2];
  logic        addr_err      [2];

  mem_stage #(.ADDR_W(AW), .MEM_LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid[0]), .ex_ready(ex_ready[0]), .ex_opcode(ex_opcode[0]),
    .ex_result(ex_result[0]), .ex_store_data(ex_store_data[0]), .ex_dest(ex_dest[0]),
    .ex_reg_write(ex_reg_write[0]), .wb_valid(wb_valid[0]), .wb_data(wb_data[0]),
    .wb_dest(wb_dest[0]), .wb_reg_write(wb_reg_write[0]), .wb_is_load(wb_is_load[0]),
    .addr_err(addr_err[0])
  );

  mem_stage #(.ADDR_W(AW), .MEM_LATENCY(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid[1]), .ex_ready(ex_ready[1]), .ex_opcode(ex_opcode[1]),
    .ex_result(ex_result[1]), .ex_store_data(ex_store_data[1]), .ex_dest(ex_dest[1]),
    .ex_reg_write(ex_reg_write[1]), .wb_valid(wb_valid[1]), .wb_data(wb_data[1]),
    .wb_dest(wb_dest[1]), .wb_reg_write(wb_reg_write[1]), .wb_is_load(wb_is_load[1]),
    .addr_err(addr_err[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h, want %h at %0t", name, d, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          lat_of [2] = '{2, 0};
  int          busy   [2];           // cycles left with ex_ready low
  logic        p_lw   [2];
  logic [31:0] p_res  [2];
  logic [31:0] p_sd   [2];
  logic [4:0]  p_dst  [2];
  logic        p_rw   [2];
  logic        e_valid[2];
  logic [31:0] e_data [2];
  logic [4:0]  e_dest [2];
  logic        e_rw   [2];
  logic        e_load [2];
  logic        e_err  [2];
  logic [31:0] mmem   [2][256];

  task automatic model_reset(input int d);
    busy[d] = 0;
    e_valid[d] = 1'b0; e_data[d] = '0; e_dest[d] = '0;
    e_rw[d] = 1'b0; e_load[d] = 1'b0; e_err[d] = 1'b0;
  endtask

  task automatic advance(input int d);
    logic       err;
    logic [7:0] idx;
    e_valid[d] = 1'b0;
    if (busy[d] > 0) begin
      busy[d]--;
      if (busy[d] == 0) begin
        err = (p_res[d] >> AW) != 0;
        idx = p_res[d][7:0];
        e_valid[d] = 1'b1;
        e_dest[d]  = p_dst[d];
        e_err[d]   = err;
        e_load[d]  = p_lw[d];
        if (p_lw[d]) begin
          e_data[d] = err ? 32'h0 : mmem[d][idx];
          e_rw[d]   = p_rw[d] & ~err;
        end else begin
          if (!err) mmem[d][idx] = p_sd[d];
          e_data[d] = p_res[d];
          e_rw[d]   = 1'b0;
        end
      end
    end else if (ex_valid[d]) begin
      if (ex_opcode[d] == OP_LW || ex_opcode[d] == OP_SW) begin
        p_lw[d]  = (ex_opcode[d] == OP_LW);
        p_res[d] = ex_result[d];
        p_sd[d]  = ex_store_data[d];
        p_dst[d] = ex_dest[d];
        p_rw[d]  = ex_reg_write[d];
        busy[d]  = lat_of[d] + 1;
      end else begin
        e_valid[d] = 1'b1;
        e_data[d]  = ex_result[d];
        e_dest[d]  = ex_dest[d];
        e_rw[d]    = ex_reg_write[d];
        e_load[d]  = 1'b0;
        e_err[d]   = 1'b0;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) model_reset(d);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) model_reset(d);
        check("wb_valid", d, wb_valid[d], e_valid[d]);
        check("wb_data", d, wb_data[d], e_data[d]);
        check("wb_dest", d, wb_dest[d], e_dest[d]);
        check("wb_reg_write", d, wb_reg_write[d], e_rw[d]);
        check("wb_is_load", d, wb_is_load[d], e_load[d]);
        check("addr_err", d, addr_err[d], e_err[d]);
        if (rst_n) begin
          check("ex_ready", d, ex_ready[d], busy[d] == 0);
          advance(d);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic send(input int d, input logic [5:0] op, input logic [31:0] res,
                      input logic [31:0] sd, input logic [4:0] dst, input logic rw);
    int waited = 0;
    ex_valid[d] = 1'b1; ex_opcode[d] = op; ex_result[d] = res;
    ex_store_data[d] = sd; ex_dest[d] = dst; ex_reg_write[d] = rw;
    @(negedge clk);
    while (!ex_ready[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ex_ready[d]) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout dut%0d: ex_ready stayed 0, want 1", d);
    end
    @(posedge clk);
    #1;
    ex_valid[d] = 1'b0;
  endtask

  task automatic wait_wb(input int d, output int lat);
    lat = 1;
    while (!wb_valid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ready_low(input int d, output int n);
    n = 0;
    while (!ex_ready[d] && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_traffic(input int d, input int n);
    logic [5:0]  op;
    logic [31:0] res;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_BNE;
        default: op = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 7) == 0)
        res = $urandom | (32'h1 << $urandom_range(AW, 31));
      else if (op == OP_LW || op == OP_SW)
        res = 32'($urandom_range(0, 255));
      else
        res = $urandom;
      send(d, op, res, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;
    int c0;
    for (int d = 0; d < 2; d++) begin
      ex_valid[d] = 1'b0; ex_opcode[d] = '0; ex_result[d] = '0;
      ex_store_data[d] = '0; ex_dest[d] = '0; ex_reg_write[d] = 1'b0;
    end
    idle(3);
    check("rst_wb_valid", 0, wb_valid[0], 1'b0);
    check("rst_wb_data", 1, wb_data[1], 32'h0);
    rst_n = 1'b1;
    idle(1);
    check("rst_ready", 0, ex_ready[0], 1'b1);
    check("rst_ready", 1, ex_ready[1], 1'b1);

    // Fill both RAMs so every later load has a defined value
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) send(d, OP_SW, 32'(i), $urandom, 5'd0, 1'b0);
    idle(4);

    // Pass-through and back-to-back throughput
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      send(0, OP_RTYPE, 32'h1234 + 32'(k), 32'h0, 5'd5, 1'b1);
      check("b2b_valid", 0, wb_valid[0], 1'b1);
      check("b2b_data", 0, wb_data[0], 32'h1234 + 32'(k));
    end
    check("b2b_dest", 0, wb_dest[0], 32'd5);
    check("b2b_is_load", 0, wb_is_load[0], 1'b0);
    check("b2b_cycles", 0, 32'(cyc - c0), 32'd4);
    idle(1);
    check("b2b_drop", 0, wb_valid[0], 1'b0);

    // sw then lw to the same index
    send(0, OP_SW, 32'd3, 32'hDEAD_BEEF, 5'd0, 1'b0);
    ready_low(0, n);
    check("sw_ready_low", 0, 32'(n), 32'd3);
    send(0, OP_LW, 32'd3, 32'h0, 5'd8, 1'b1);
    wait_wb(0, lat);
    check("lw_latency", 0, 32'(lat), 32'd4);
    check("lw_data", 0, wb_data[0], 32'hDEAD_BEEF);
    check("lw_reg_write", 0, wb_reg_write[0], 1'b1);
    check("lw_dest", 0, wb_dest[0], 32'd8);

    // Out-of-range index
    send(0, OP_SW, 32'd0, 32'h1111_2222, 5'd0, 1'b0);
    send(0, OP_LW, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
    wait_wb(0, lat);
    check("oor_lw_err", 0, addr_err[0], 1'b1);
    check("oor_lw_rw", 0, wb_reg_write[0], 1'b0);
    check("oor_lw_data", 0, wb_data[0], 32'h0);
    send(0, OP_SW, 32'h0000_0100, 32'hFFFF_FFFF, 5'd0, 1'b0);
    wait_wb(0, lat);
    check("oor_sw_err", 0, addr_err[0], 1'b1);
    send(0, OP_LW, 32'd0, 32'h0, 5'd10, 1'b1);
    wait_wb(0, lat);
    check("idx0_kept", 0, wb_data[0], 32'h1111_2222);
    check("idx0_err", 0, addr_err[0], 1'b0);

    // Reset while a store waits: store dropped, no writeback
    send(0, OP_SW, 32'd7, 32'hCAFE_0007, 5'd0, 1'b0);
    wait_wb(0, lat);
    send(0, OP_SW, 32'd7, 32'h0000_0001, 5'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 0, wb_data[0], 32'h0);
    check("mid_rst_valid", 0, wb_valid[0], 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_ready", 0, ex_ready[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("no_wb_after_rst", 0, wb_valid[0], 1'b0);
      idle(1);
    end
    send(0, OP_LW, 32'd7, 32'h0, 5'd3, 1'b1);
    wait_wb(0, lat);
    check("dropped_sw", 0, wb_data[0], 32'hCAFE_0007);

    // Zero-latency build
    send(1, OP_SW, 32'd5, 32'h0BAD_F00D, 5'd0, 1'b0);
    ready_low(1, n);
    check("l0_ready_low", 1, 32'(n), 32'd1);
    send(1, OP_LW, 32'd5, 32'h0, 5'd4, 1'b1);
    wait_wb(1, lat);
    check("l0_latency", 1, 32'(lat), 32'd2);
    check("l0_data", 1, wb_data[1], 32'h0BAD_F00D);

    rand_traffic(0, 300);
    rand_traffic(1, 300);
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
